// File: rtl/uart_frame_receiver.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority voting.
// Delivers bytes on a valid/ready handshake and pulses framing and overrun errors.
`timescale 1ns/1ps
module uart_frame_receiver #(
  parameter int CLK_FREQUENCY = 10000000,
  parameter int BAUD_RATE     = 57600
) (
  input  logic       clki,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV_RAW = CLK_FREQUENCY / (BAUD_RATE * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t          state_r;
  state_t          state_next_s;
  logic            sync1_r;
  logic            rxs_r;
  logic            prev_r;
  logic            edge_r;
  logic [CW-1:0]   cnt_r;
  logic [3:0]      s_r;
  logic [3:0]      b_r;
  logic [1:0]      samp_r;
  logic [7:0]      shift_r;
  logic            tick_s;
  logic            maj_s;
  logic            mid_s;
  logic            last_s;
  logic            deliver_s;
  logic            ferr_s;

  assign tick_s = (state_r != IDLE) && (cnt_r == DIV_LAST);
  assign mid_s  = tick_s && (s_r == 4'd9);
  assign last_s = tick_s && (s_r == 4'd15);
  assign maj_s  = majority3(samp_r[1], samp_r[0], rxs_r);

  // Line synchronizer and registered falling-edge detector.
  always_ff @(posedge clki) begin
    if (reset) begin
      sync1_r <= 1'b1;
      rxs_r   <= 1'b1;
      prev_r  <= 1'b1;
      edge_r  <= 1'b0;
    end else begin
      sync1_r <= rx;
      rxs_r   <= sync1_r;
      prev_r  <= rxs_r;
      edge_r  <= ~rxs_r & prev_r;
    end
  end

  // Frame state register.
  always_ff @(posedge clki) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic plus the stop-bit verdict strobes.
  always_comb begin
    state_next_s = state_r;
    deliver_s    = 1'b0;
    ferr_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (edge_r) state_next_s = START;
        else        state_next_s = IDLE;
      end
      START: begin
        if (mid_s && maj_s) state_next_s = IDLE;
        else if (last_s)    state_next_s = DATA;
        else                state_next_s = START;
      end
      DATA: begin
        if (last_s && (b_r == 4'd8)) state_next_s = STOP;
        else                         state_next_s = DATA;
      end
      STOP: begin
        if (mid_s) begin
          state_next_s = IDLE;
          if (maj_s) deliver_s = 1'b1;
          else       ferr_s    = 1'b1;
        end else begin
          state_next_s = STOP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Oversampling counters, data shift register and the handshake outputs.
  always_ff @(posedge clki) begin
    if (reset) begin
      cnt_r       <= '0;
      s_r         <= 4'd0;
      b_r         <= 4'd0;
      samp_r      <= 2'b11;
      shift_r     <= 8'h00;
      data        <= 8'h00;
      valid       <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_error <= ferr_s;
      overrun     <= 1'b0;
      busy        <= (state_next_s != IDLE);
      // Holding the divider at zero while idle restarts bit timing at each start edge.
      if (state_r == IDLE) begin
        cnt_r <= '0;
        s_r   <= 4'd0;
        b_r   <= 4'd0;
      end else if (tick_s) begin
        cnt_r <= '0;
        s_r   <= s_r + 4'd1;
        if (s_r == 4'd15) b_r <= b_r + 4'd1;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
      if (tick_s && ((s_r == 4'd7) || (s_r == 4'd8))) begin
        samp_r <= {samp_r[0], rxs_r};
      end
      if ((state_r == DATA) && mid_s) begin
        shift_r <= {maj_s, shift_r[7:1]};
      end
      if (deliver_s) begin
        if (!valid || ready) begin
          data  <= shift_r;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Directed bench for uart_frame_receiver at 16 clocks per bit (DIV=1).
// A frame-schedule model predicts every output per cycle; literal checks pin the model.
`timescale 1ns/1ps
module tb_uart_frame_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  uart_frame_receiver #(
    .CLK_FREQUENCY(16000000),
    .BAUD_RATE    (1000000)
  ) dut (
    .clki       (clk),
    .reset      (reset),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frame_error(frame_error),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A frame whose line drop is driven during cycle t: busy from t+4 to busy_end,
  // and (if it reaches a stop verdict) the verdict shows on the outputs at t+158.
  typedef struct {
    int         t;
    logic [7:0] byt;
    logic       stopb;
    int         busy_end;
    bit         decides;
  } frame_t;

  frame_t     frames[$];
  int         rise_cyc[$];
  logic [7:0] rise_dat[$];
  int         fe_cyc[$];
  int         ov_cyc[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int rise_at(input int i);
    return (i < rise_cyc.size()) ? rise_cyc[i] : -1;
  endfunction

  function automatic int dat_at(input int i);
    return (i < rise_dat.size()) ? int'(rise_dat[i]) : -1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] byt, input logic stopb);
    logic [9:0] f;
    frame_t     fr;
    f = {stopb, byt, 1'b0};
    fr.t = cyc; fr.byt = byt; fr.stopb = stopb; fr.busy_end = cyc + 157; fr.decides = 1'b1;
    frames.push_back(fr);
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      step(16);
    end
  endtask

  // Per-cycle model and comparison.
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       rst_prev = 1'b1;
  logic       rdy_prev = 1'b1;
  logic       obs_prev_valid = 1'b0;

  always @(negedge clk) begin : model
    logic       e_busy;
    logic       e_fe;
    logic       e_ov;
    bit         found;
    logic [7:0] dbyte;
    logic       dstop;
    e_busy = 1'b0; e_fe = 1'b0; e_ov = 1'b0; found = 1'b0; dbyte = 8'h00; dstop = 1'b0;
    foreach (frames[i]) begin
      if (cyc >= frames[i].t + 4 && cyc <= frames[i].busy_end) e_busy = 1'b1;
      if (frames[i].decides && cyc == frames[i].t + 158) begin
        found = 1'b1; dbyte = frames[i].byt; dstop = frames[i].stopb;
      end
    end
    if (rst_prev) begin
      m_valid = 1'b0; m_data = 8'h00; e_busy = 1'b0;
    end else if (found && dstop) begin
      if (!m_valid || rdy_prev) begin
        m_valid = 1'b1; m_data = dbyte;
      end else begin
        e_ov = 1'b1;
      end
    end else if (found) begin
      e_fe = 1'b1;
      if (m_valid && rdy_prev) m_valid = 1'b0;
    end else if (m_valid && rdy_prev) begin
      m_valid = 1'b0;
    end
    chk("valid", valid, m_valid);
    if (m_valid) chk("data", data, m_data);
    chk("busy", busy, e_busy);
    chk("frame_error", frame_error, e_fe);
    chk("overrun", overrun, e_ov);
    if (valid === 1'b1 && obs_prev_valid !== 1'b1) begin
      rise_cyc.push_back(cyc);
      rise_dat.push_back(data);
    end
    if (frame_error === 1'b1) fe_cyc.push_back(cyc);
    if (overrun === 1'b1) ov_cyc.push_back(cyc);
    obs_prev_valid = valid;
    rst_prev = reset;
    rdy_prev = ready;
  end

  initial begin : stim
    int         t;
    int         t2;
    int         m;
    int         r0;
    int         f0;
    int         o0;
    logic [9:0] f;
    frame_t     fr;

    step(3);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fe", frame_error, 0);
    chk("rst_ov", overrun, 0);
    reset = 1'b0;
    step(10);

    // Single byte
    r0 = rise_cyc.size(); f0 = fe_cyc.size(); o0 = ov_cyc.size();
    t = cyc;
    send_frame(8'hA5, 1'b1);
    step(20);
    chk("a5_count", rise_cyc.size() - r0, 1);
    chk("a5_cycle", rise_at(r0), t + 158);
    chk("a5_data", dat_at(r0), 8'hA5);
    chk("a5_flags", (fe_cyc.size() - f0) + (ov_cyc.size() - o0), 0);
    chk("a5_busy_end", busy, 0);

    // Back-to-back
    r0 = rise_cyc.size();
    t = cyc;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    step(20);
    chk("b2b_count", rise_cyc.size() - r0, 3);
    chk("b2b_c0", rise_at(r0), t + 158);
    chk("b2b_c1", rise_at(r0 + 1), t + 318);
    chk("b2b_c2", rise_at(r0 + 2), t + 478);
    chk("b2b_d0", dat_at(r0), 8'h00);
    chk("b2b_d1", dat_at(r0 + 1), 8'hFF);
    chk("b2b_d2", dat_at(r0 + 2), 8'h3C);

    // Overrun
    r0 = rise_cyc.size(); o0 = ov_cyc.size();
    ready = 1'b0;
    t = cyc;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    step(10);
    chk("ovr_count", ov_cyc.size() - o0, 1);
    chk("ovr_cycle", (ov_cyc.size() > o0) ? ov_cyc[o0] : -1, t + 318);
    chk("ovr_hold_valid", valid, 1);
    chk("ovr_hold_data", data, 8'h11);
    ready = 1'b1;
    step(1);
    chk("ovr_drop", valid, 0);
    step(20);
    chk("ovr_rises", rise_cyc.size() - r0, 1);
    chk("ovr_rise_data", dat_at(r0), 8'h11);

    // Framing error followed by a good frame
    r0 = rise_cyc.size(); f0 = fe_cyc.size();
    t = cyc;
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    step(40);
    rx = 1'b1;
    step(20);
    t2 = cyc;
    send_frame(8'h66, 1'b1);
    step(20);
    chk("fe_count", fe_cyc.size() - f0, 1);
    chk("fe_cycle", (fe_cyc.size() > f0) ? fe_cyc[f0] : -1, t + 158);
    chk("fe_rises", rise_cyc.size() - r0, 1);
    chk("fe_next_cycle", rise_at(r0), t2 + 158);
    chk("fe_next_data", dat_at(r0), 8'h66);

    // Glitch rejection
    r0 = rise_cyc.size(); f0 = fe_cyc.size();
    t = cyc;
    fr.t = t; fr.byt = 8'h00; fr.stopb = 1'b1; fr.busy_end = t + 13; fr.decides = 1'b0;
    frames.push_back(fr);
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(30);
    chk("gl_rises", rise_cyc.size() - r0, 0);
    chk("gl_fe", fe_cyc.size() - f0, 0);
    chk("gl_busy", busy, 0);

    // Reset in the middle of bit 4
    r0 = rise_cyc.size(); f0 = fe_cyc.size(); o0 = ov_cyc.size();
    t = cyc;
    m = t + 72;
    fr.t = t; fr.byt = 8'h81; fr.stopb = 1'b1; fr.busy_end = m; fr.decides = 1'b0;
    frames.push_back(fr);
    f = {1'b1, 8'h81, 1'b0};
    for (int i = 0; i < 4; i++) begin
      rx = f[i];
      step(16);
    end
    rx = f[4];
    step(8);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    step(1);
    chk("mr_valid", valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_data", data, 8'h00);
    chk("mr_fe", frame_error, 0);
    chk("mr_ov", overrun, 0);
    reset = 1'b0;
    rx = 1'b1;
    step(20);
    t2 = cyc;
    send_frame(8'h7E, 1'b1);
    step(20);
    chk("mr_rises", rise_cyc.size() - r0, 1);
    chk("mr_next_cycle", rise_at(r0), t2 + 158);
    chk("mr_next_data", dat_at(r0), 8'h7E);
    chk("mr_flags", (fe_cyc.size() - f0) + (ov_cyc.size() - o0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
